decimal_entry_peripheral: RTL
=============================

Name: decimal_entry_peripheral

Overview:
Input-side counterpart of the 7-segment decimal display path. It accepts keypad key events and builds a signed decimal number of up to 10 digits as BCD, with sign, backspace and clear. On enter, it converts the BCD entry to a signed 32-bit binary word using a sequential one-digit-per-cycle multiply-accumulate, then holds the result for the CPU until acknowledged. It sits between the keypad scanner/debouncer and the memory-mapped I/O read path.

Parameters:
MAX_DIGITS, 10, maximum number of decimal digits accepted (legal range 1..10).

Ports:
clk  input  1  system clock; one clock domain, all logic rising-edge.
rst  input  1  synchronous, active-high reset.
key_valid  input  1  single-cycle strobe; key_code is valid this cycle.
key_code  input  4  0x0-0x9 digit; 0xA sign toggle; 0xB backspace; 0xC clear; 0xE enter; 0xD/0xF ignored.
data_ack  input  1  CPU has consumed data_out; sampled only while data_valid=1.
entry_bcd  output  4*MAX_DIGITS  live BCD entry, least significant digit in [3:0].
entry_count  output  4  number of digits entered.
entry_neg  output  1  live sign of the entry.
busy  output  1  high in CONVERT and DONE.
data_out  output  32  signed converted result.
data_valid  output  1  result available.
overflow  output  1  result was saturated.

Behaviour:
- Reset: state=ENTRY. entry_bcd, entry_count, entry_neg, busy, data_out, data_valid and overflow all 0. rst has priority over every other input in every state, including mid-CONVERT.
- ENTRY state. Each key_valid pulse acts on the next clock edge:
  - Digit d, entry_count<MAX_DIGITS: entry_bcd={entry_bcd<<4}|d and entry_count+1.
  - Leading zero (entry_count==0, d==0): ignored.
  - Digit with entry_count==MAX_DIGITS: ignored.
  - 0xA: toggle entry_neg.
  - 0xB with entry_count>0: entry_bcd>>4, entry_count-1. With entry_count==0: no change.
  - 0xC: entry_bcd=0, entry_count=0, entry_neg=0.
  - 0xE: go to CONVERT. acc=0, digit index=MAX_DIGITS-1, busy=1 on the following cycle. Enter with entry_count==0 is legal and converts to 0.
- CONVERT state:
  - Exactly MAX_DIGITS cycles. Each cycle: acc = acc*10 + entry_bcd[idx], processing the most significant digit first; idx decrements.
  - Accumulator width is 34 bits unsigned; the maximum value 9,999,999,999 fits, so no internal wrap.
  - All key_valid input is ignored.
- CONVERT to DONE (registered on the last digit):
  - !entry_neg: data_out = acc if acc<=2147483647; otherwise data_out=0x7FFFFFFF and overflow=1.
  - entry_neg: data_out = -acc if acc<=2147483648 (2147483648 gives 0x80000000 with overflow=0); otherwise data_out=0x80000000 and overflow=1.
  - Negative zero gives 0.
  - data_valid=1 exactly MAX_DIGITS+1 cycles after the enter edge.
- DONE state:
  - data_out, overflow and data_valid hold steady. Keys are ignored.
  - On data_ack: next cycle data_valid=0, overflow=0, busy=0, entry cleared (bcd, count, neg), state=ENTRY. data_out retains its last value.
  - data_ack together with key_valid: the ack is processed and the key is dropped.
  - data_ack outside DONE is ignored.
- entry_* outputs remain visible during CONVERT and DONE for display echo.

Decomposition:
- Shared package holds:
  - key code constants: KEY_NEG=4'hA, KEY_BS=4'hB, KEY_CLR=4'hC, KEY_ENT=4'hE;
  - state encoding: ENTRY, CONVERT, DONE;
  - saturation constants: POS_MAX=32'h7FFFFFFF, NEG_MIN=32'h80000000.
- One natural sub-module, dec_mac10: combinational 34-bit acc*10+digit, computed as (acc<<3)+(acc<<1)+d. The FSM, entry registers and saturation logic stay in the top block.

Test Plan:
- Keys 1,2,3, enter -> busy for 10 cycles, then data_valid=1, data_out=0x0000007B, overflow=0. Ack -> entry_count=0, busy=0, data_valid=0.
- Keys 0xA,4,5, enter -> data_out=0xFFFFFFD3 (-45), overflow=0.
- Ten 9s, then an 11th 9 (ignored; entry_count stays 10), enter -> data_out=0x7FFFFFFF, overflow=1.
- Negative 2147483648 -> data_out=0x80000000, overflow=0. Negative 2147483649 -> data_out=0x80000000, overflow=1.
- Keys 0,0,7,0xB,8 -> entry_bcd=0x8, entry_count=1. Then 0xA,0xC -> entry_bcd=0, entry_neg=0, entry_count=0.
- Reset asserted mid-CONVERT -> all outputs 0 and ENTRY next cycle. Keys during DONE and data_ack during ENTRY -> no effect.

Source files
------------

// File: rtl/decimal_entry_peripheral_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decimal_entry_peripheral_pkg : key codes, FSM states, saturation limits
// Rev 1.0
// ---------------------------------------------------------------------------
package decimal_entry_peripheral_pkg;

   localparam logic [3:0] KEY_NEG = 4'hA;
   localparam logic [3:0] KEY_BS  = 4'hB;
   localparam logic [3:0] KEY_CLR = 4'hC;
   localparam logic [3:0] KEY_ENT = 4'hE;

   localparam logic [31:0] POS_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] NEG_MIN = 32'h8000_0000;

   localparam int ACC_W = 34;

   typedef enum logic [1:0] {
      ENTRY   = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/decimal_entry_peripheral_mac10.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dec_mac10 : combinational acc*10 + digit using shift-add
// Rev 1.0
// ---------------------------------------------------------------------------
module dec_mac10
   import decimal_entry_peripheral_pkg::*;
(
   input  logic [ACC_W-1:0] i_acc,
   input  logic [3:0]       i_digit,
   output logic [ACC_W-1:0] o_result
);

   assign o_result = (i_acc << 3) + (i_acc << 1) + ACC_W'(i_digit);

endmodule
`default_nettype wire

// File: rtl/decimal_entry_peripheral.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decimal_entry_peripheral : keypad BCD entry with signed binary conversion
// Rev 1.0
// ---------------------------------------------------------------------------
module decimal_entry_peripheral
   import decimal_entry_peripheral_pkg::*;
#(
   parameter int MAX_DIGITS = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    key_valid,
   input  logic [3:0]              key_code,
   input  logic                    data_ack,
   output logic [4*MAX_DIGITS-1:0] entry_bcd,
   output logic [3:0]              entry_count,
   output logic                    entry_neg,
   output logic                    busy,
   output logic [31:0]             data_out,
   output logic                    data_valid,
   output logic                    overflow
);

   localparam int               BCD_W      = 4 * MAX_DIGITS;
   localparam logic [3:0]       c_max_cnt  = 4'(MAX_DIGITS);
   localparam logic [3:0]       c_last_idx = 4'(MAX_DIGITS - 1);
   localparam logic [ACC_W-1:0] c_pos_lim  = 34'd2147483647;
   localparam logic [ACC_W-1:0] c_neg_lim  = 34'd2147483648;

   state_t             r_state;
   state_t             w_next;
   logic [BCD_W-1:0]   r_bcd;
   logic [3:0]         r_count;
   logic               r_neg;
   logic [ACC_W-1:0]   r_acc;
   logic [3:0]         r_idx;
   logic [31:0]        r_dout;
   logic               r_valid;
   logic               r_ovf;

   logic [BCD_W-1:0]   w_bcd_sh;
   logic [3:0]         w_digit;
   logic [ACC_W-1:0]   w_mac;
   logic               w_last;
   logic               w_accept_digit;
   logic [31:0]        w_sat_val;
   logic               w_sat_ovf;

   assign w_bcd_sh       = r_bcd >> {r_idx, 2'b00};
   assign w_digit        = w_bcd_sh[3:0];
   assign w_last         = (r_idx == 4'd0);
   // leading zeros never enter the buffer so the digit count stays meaningful
   assign w_accept_digit = (r_count < c_max_cnt) && !((r_count == 4'd0) && (key_code == 4'd0));

   dec_mac10 u_mac (
      .i_acc    (r_acc),
      .i_digit  (w_digit),
      .o_result (w_mac)
   );

   always_comb begin
      w_sat_val = w_mac[31:0];
      w_sat_ovf = 1'b0;
      if (!r_neg) begin
         if (w_mac > c_pos_lim) begin
            w_sat_val = POS_MAX;
            w_sat_ovf = 1'b1;
         end
      end else if (w_mac > c_neg_lim) begin
         w_sat_val = NEG_MIN;
         w_sat_ovf = 1'b1;
      end else begin
         w_sat_val = 32'd0 - w_mac[31:0];
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ENTRY:   if (key_valid && (key_code == KEY_ENT)) w_next = CONVERT;
         CONVERT: if (w_last) w_next = DONE;
         DONE:    if (data_ack) w_next = ENTRY;
         default: w_next = ENTRY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ENTRY;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bcd   <= '0;
         r_count <= 4'd0;
         r_neg   <= 1'b0;
         r_acc   <= '0;
         r_idx   <= 4'd0;
         r_dout  <= 32'd0;
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            ENTRY: begin
               if (key_valid) begin
                  if (key_code <= 4'd9) begin
                     if (w_accept_digit) begin
                        r_bcd   <= (r_bcd << 4) | BCD_W'(key_code);
                        r_count <= r_count + 4'd1;
                     end
                  end else begin
                     case (key_code)
                        KEY_NEG: r_neg <= ~r_neg;
                        KEY_BS: begin
                           if (r_count != 4'd0) begin
                              r_bcd   <= r_bcd >> 4;
                              r_count <= r_count - 4'd1;
                           end
                        end
                        KEY_CLR: begin
                           r_bcd   <= '0;
                           r_count <= 4'd0;
                           r_neg   <= 1'b0;
                        end
                        KEY_ENT: begin
                           r_acc <= '0;
                           r_idx <= c_last_idx;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            CONVERT: begin
               r_acc <= w_mac;
               if (w_last) begin
                  r_dout  <= w_sat_val;
                  r_ovf   <= w_sat_ovf;
                  r_valid <= 1'b1;
               end else begin
                  r_idx <= r_idx - 4'd1;
               end
            end
            DONE: begin
               if (data_ack) begin
                  r_valid <= 1'b0;
                  r_ovf   <= 1'b0;
                  r_bcd   <= '0;
                  r_count <= 4'd0;
                  r_neg   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign entry_bcd   = r_bcd;
   assign entry_count = r_count;
   assign entry_neg   = r_neg;
   assign busy        = (r_state != ENTRY);
   assign data_out    = r_dout;
   assign data_valid  = r_valid;
   assign overflow    = r_ovf;

endmodule
`default_nettype wire
